// File: rtl/axi_mem_slave_if.sv
// AXI3 bus bundle between a master and the axi_mem_slave memory.
// Slave modport is used by the memory, master modport by a driver.
interface axi_mem_slave_if #(
    parameter int WIDTH_ID = 4,
    parameter int WIDTH_DA = 32
);
    localparam int WIDTH_DS = WIDTH_DA / 8;

    logic [WIDTH_ID-1:0] AWID;
    logic [31:0]         AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [WIDTH_DA-1:0] WDATA;
    logic [WIDTH_DS-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [WIDTH_ID-1:0] BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    logic [WIDTH_ID-1:0] ARID;
    logic [31:0]         ARADDR;
    logic [3:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [WIDTH_ID-1:0] RID;
    logic [WIDTH_DA-1:0] RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI3 slave memory: independent write and read engines, one burst each,
// FIXED/INCR/WRAP, narrow sizes, strobes and SLVERR reporting.
module axi_mem_slave #(
    parameter int WIDTH_ID    = 4,
    parameter int WIDTH_DA    = 32,
    parameter int ADDR_LENGTH = 12
) (
    input logic             ACLK,
    input logic             ARESET,
    axi_mem_slave_if.slave  s
);
    localparam int WIDTH_DS = WIDTH_DA / 8;
    localparam int LB       = $clog2(WIDTH_DS);
    localparam int AL       = ADDR_LENGTH;
    localparam int DEPTH    = 1 << (AL - LB);

    typedef logic [AL-1:0] addr_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [WIDTH_DA-1:0] r_mem [DEPTH];

    wstate_t             r_wstate;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [WIDTH_ID-1:0] r_bid;
    logic [1:0]          r_bresp;
    addr_t               r_waddr;
    logic [3:0]          r_wlen;
    logic [2:0]          r_wsize;
    logic [1:0]          r_wburst;
    logic [3:0]          r_wcnt;
    logic                r_werr;
    logic                r_wover;

    rstate_t             r_rstate;
    logic                r_arready;
    logic                r_rvalid;
    logic                r_rlast;
    logic [WIDTH_ID-1:0] r_rid;
    logic [1:0]          r_rresp;
    logic [WIDTH_DA-1:0] r_rdata;
    addr_t               r_raddr;
    logic [3:0]          r_rlen;
    logic [2:0]          r_rsize;
    logic [1:0]          r_rburst;
    logic [3:0]          r_rcnt;
    logic                r_rover;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_aw_over, w_ar_over, w_wlast_bad;
    logic w_unused;

    assign w_aw_hs     = s.AWVALID & r_awready;
    assign w_w_hs      = s.WVALID & r_wready;
    assign w_b_hs      = r_bvalid & s.BREADY;
    assign w_ar_hs     = s.ARVALID & r_arready;
    assign w_r_hs      = r_rvalid & s.RREADY;
    assign w_aw_over   = s.AWSIZE > 3'(LB);
    assign w_ar_over   = s.ARSIZE > 3'(LB);
    assign w_wlast_bad = s.WLAST != (r_wcnt == r_wlen);
    assign w_unused    = ^{s.AWADDR[31:AL], s.ARADDR[31:AL]};

    assign s.AWREADY = r_awready;
    assign s.WREADY  = r_wready;
    assign s.BVALID  = r_bvalid;
    assign s.BID     = r_bid;
    assign s.BRESP   = r_bresp;
    assign s.ARREADY = r_arready;
    assign s.RVALID  = r_rvalid;
    assign s.RLAST   = r_rlast;
    assign s.RID     = r_rid;
    assign s.RRESP   = r_rresp;
    assign s.RDATA   = r_rdata;

    // Reserved burst type falls through to INCR; odd WRAP lengths too.
    function automatic addr_t f_next(
        input addr_t      a,
        input logic [3:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        addr_t w_sz;
        addr_t w_inc;
        addr_t w_bnd;
        logic  w_wrap;
        w_sz   = addr_t'(1) << size;
        w_inc  = (a & ~(w_sz - addr_t'(1))) + w_sz;
        w_wrap = (burst == 2'd2) &&
                 (len == 4'd1 || len == 4'd3 ||
                  len == 4'd7 || len == 4'd15);
        case (len)
            4'd1:    w_bnd = w_sz << 1;
            4'd3:    w_bnd = w_sz << 2;
            4'd7:    w_bnd = w_sz << 3;
            default: w_bnd = w_sz << 4;
        endcase
        if (burst == 2'd0)
            return a;
        else if (w_wrap)
            return (a & ~(w_bnd - addr_t'(1))) |
                   (w_inc & (w_bnd - addr_t'(1)));
        else
            return w_inc;
    endfunction

    always_ff @(posedge ACLK) begin
        if (w_w_hs && !r_wover) begin
            for (int i = 0; i < WIDTH_DS; i++) begin
                if (s.WSTRB[i])
                    r_mem[r_waddr[AL-1:LB]][8*i +: 8] <=
                        s.WDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= 2'd0;
            r_waddr   <= '0;
            r_wlen    <= 4'd0;
            r_wsize   <= 3'd0;
            r_wburst  <= 2'd0;
            r_wcnt    <= 4'd0;
            r_werr    <= 1'b0;
            r_wover   <= 1'b0;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_bid     <= s.AWID;
                        r_waddr   <= s.AWADDR[AL-1:0];
                        r_wlen    <= s.AWLEN;
                        r_wsize   <= s.AWSIZE;
                        r_wburst  <= s.AWBURST;
                        r_wcnt    <= 4'd0;
                        r_wover   <= w_aw_over;
                        r_werr    <= w_aw_over ||
                                     (s.AWBURST == 2'd3);
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_waddr <= f_next(r_waddr, r_wlen,
                                          r_wsize, r_wburst);
                        r_wcnt  <= r_wcnt + 4'd1;
                        r_werr  <= r_werr | w_wlast_bad;
                        if (r_wcnt == r_wlen) begin
                            r_bresp  <= (r_werr | w_wlast_bad) ?
                                        2'd2 : 2'd0;
                            r_bvalid <= 1'b1;
                            r_wready <= 1'b0;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rresp   <= 2'd0;
            r_rdata   <= '0;
            r_raddr   <= '0;
            r_rlen    <= 4'd0;
            r_rsize   <= 3'd0;
            r_rburst  <= 2'd0;
            r_rcnt    <= 4'd0;
            r_rover   <= 1'b0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid     <= s.ARID;
                        r_rlen    <= s.ARLEN;
                        r_rsize   <= s.ARSIZE;
                        r_rburst  <= s.ARBURST;
                        r_rover   <= w_ar_over;
                        r_rresp   <= (w_ar_over ||
                                      s.ARBURST == 2'd3) ?
                                     2'd2 : 2'd0;
                        r_rdata   <= w_ar_over ? '0 :
                                     r_mem[s.ARADDR[AL-1:LB]];
                        r_raddr   <= f_next(s.ARADDR[AL-1:0],
                                            s.ARLEN, s.ARSIZE,
                                            s.ARBURST);
                        r_rcnt    <= 4'd1;
                        r_rlast   <= (s.ARLEN == 4'd0);
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs && r_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end else if (w_r_hs) begin
                        r_rdata <= r_rover ? '0 :
                                   r_mem[r_raddr[AL-1:LB]];
                        r_rlast <= (r_rcnt == r_rlen);
                        r_rcnt  <= r_rcnt + 4'd1;
                        r_raddr <= f_next(r_raddr, r_rlen,
                                          r_rsize, r_rburst);
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end
endmodule
